// File: rtl/alu_flag_decoder.sv
// alu_flag_decoder
//   Receive-side decoder for the {zero_flag, data[1:0]} flag code stream.
//   Each code's zero flag is checked against its data bits. CODES codes are
//   packed MS-first into one registered word, which is presented on a
//   valid/ready stream together with per-word error and all-zero flags.
//   A saturating counter tallies inconsistent codes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_code is valid
//   in_ready   decoder can accept in_code this cycle (combinational)
//   in_code    [2] zero flag, [1:0] data bits
//   out_valid  out_data/out_err/out_zero are valid
//   out_ready  downstream accepts the current word
//   out_data   packed word, first code received in the top 2 bits
//   out_err    at least one code in the word had an inconsistent flag
//   out_zero   every code in the word was 3'b100
//   err_count  saturating count of inconsistent codes accepted
//   clr_err    clear err_count (wins over a same-cycle increment)
module alu_flag_decoder #(
    parameter int unsigned CODES = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*CODES-1:0]   out_data,
    output logic                 out_err,
    output logic                 out_zero,
    output logic [CNT_W-1:0]     err_count,
    input  logic                 clr_err
);

    localparam int unsigned W     = 2 * CODES;
    localparam int unsigned IDX_W = (CODES > 1) ? $clog2(CODES) : 1;

    logic [W-1:0]     r_shift;
    logic [IDX_W-1:0] r_idx;
    logic             r_err_acc;
    logic             r_zero_acc;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic             r_out_err;
    logic             r_out_zero;
    logic [CNT_W-1:0] r_err_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_incons;
    logic             w_last;
    logic [W-1:0]     w_shift;
    logic             w_err_next;
    logic             w_zero_next;

    // The only stall source is a held output word.
    assign w_in_ready  = !r_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    assign w_incons    = in_code[2] != ~|in_code[1:0];
    assign w_last      = (r_idx == IDX_W'(CODES - 1));
    // New code enters at the LSB end; the oldest bits fall off the top.
    assign w_shift     = (r_shift << 2) | W'(in_code[1:0]);
    assign w_err_next  = r_err_acc | w_incons;
    assign w_zero_next = r_zero_acc & (in_code == 3'b100);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_idx       <= '0;
            r_err_acc   <= 1'b0;
            r_zero_acc  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            // Handshake retires the word; a completion below re-raises
            // valid in the same cycle for back-to-back words.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_last) begin
                    r_out_data  <= w_shift;
                    r_out_err   <= w_err_next;
                    r_out_zero  <= w_zero_next;
                    r_out_valid <= 1'b1;
                    r_shift     <= '0;
                    r_idx       <= '0;
                    r_err_acc   <= 1'b0;
                    r_zero_acc  <= 1'b1;
                end else begin
                    r_shift     <= w_shift;
                    r_idx       <= r_idx + 1'b1;
                    r_err_acc   <= w_err_next;
                    r_zero_acc  <= w_zero_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            r_err_count <= '0;
        end else if (w_accept && w_incons && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign out_zero  = r_out_zero;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_flag_decoder.sv
// tb_alu_flag_decoder
//   Directed and randomized checks of alu_flag_decoder (CODES=2, CNT_W=2)
//   against a behavioural word-packing model kept in this bench.
module tb_alu_flag_decoder;

    localparam int unsigned CODES = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned W     = 2 * CODES;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_code;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_err;
    logic             out_zero;
    logic [CNT_W-1:0] err_count;
    logic             clr_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic     m_valid;
    int       m_data;
    logic     m_err;
    logic     m_zero;
    int       m_cnt;
    int       part[$];
    int       n_acc;

    always #5 clk = ~clk;

    alu_flag_decoder #(.CODES(CODES), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_zero  (out_zero),
        .err_count (err_count),
        .clr_err   (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Only 100, 001, 010 and 011 are well-formed codes.
    function automatic bit is_bad(input int c);
        return !(c == 4 || c == 1 || c == 2 || c == 3);
    endfunction

    // One clock with the inputs already driven: check in_ready, advance the
    // model, then compare every registered output just after the edge.
    task automatic cycle();
        bit acc;
        int d;
        bit e;
        bit z;
        @(negedge clk);
        if (!rst) check("in_ready", in_ready, (!m_valid || out_ready));
        if (rst) begin
            m_valid = 0; m_data = 0; m_err = 0; m_zero = 0; m_cnt = 0;
            part.delete();
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 0;
            if (clr_err) m_cnt = 0;
            else if (acc && is_bad(in_code) && m_cnt < CMAX) m_cnt++;
            if (acc) begin
                n_acc++;
                part.push_back(int'(in_code));
                if (part.size() == CODES) begin
                    d = 0; e = 0; z = 1;
                    foreach (part[i]) begin
                        d = d * 4 + (part[i] % 4);
                        if (is_bad(part[i])) e = 1;
                        if (part[i] != 4) z = 0;
                    end
                    m_data = d; m_err = e; m_zero = z; m_valid = 1;
                    part.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_err", out_err, m_err);
        check("out_zero", out_zero, m_zero);
        check("err_count", err_count, m_cnt);
    endtask

    task automatic drive(input bit v, input logic [2:0] c, input bit ordy,
                         input bit clr, input bit r);
        in_valid  = v;
        in_code   = c;
        out_ready = ordy;
        clr_err   = clr;
        rst       = r;
        cycle();
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_err = 0; m_zero = 0; m_cnt = 0; n_acc = 0;
        in_valid = 0; in_code = 3'b000; out_ready = 1; clr_err = 0; rst = 1;
        @(posedge clk); #1;
        drive(0, 3'b000, 1, 0, 1);
        drive(0, 3'b000, 1, 0, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic packing, MS-first
        drive(1, 3'b010, 1, 0, 0);
        check("t1_no_early_valid", out_valid, 0);
        drive(1, 3'b011, 1, 0, 0);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 4'b1011);
        check("t1_err", out_err, 0);
        check("t1_zero", out_zero, 0);
        drive(0, 3'b000, 1, 0, 0);
        check("t1_valid_drop", out_valid, 0);

        // All-zero words
        drive(1, 3'b100, 1, 0, 0);
        drive(1, 3'b100, 1, 0, 0);
        check("t2_data", out_data, 0);
        check("t2_zero", out_zero, 1);
        check("t2_err", out_err, 0);
        drive(1, 3'b100, 1, 0, 0);
        drive(1, 3'b001, 1, 0, 0);
        check("t2_zero_clear", out_zero, 0);
        check("t2_data2", out_data, 4'b0001);

        // Inconsistent codes and error counting
        drive(1, 3'b110, 1, 0, 0);
        drive(1, 3'b001, 1, 0, 0);
        check("t3_data", out_data, 4'b1001);
        check("t3_err", out_err, 1);
        check("t3_cnt1", err_count, 1);
        drive(1, 3'b000, 1, 0, 0);
        drive(1, 3'b000, 1, 0, 0);
        check("t3_cnt3", err_count, 3);
        check("t3_data0", out_data, 0);
        check("t3_zero0", out_zero, 0);
        check("t3_err1", out_err, 1);

        // Saturation, then clear beating an increment
        drive(1, 3'b101, 1, 0, 0);
        drive(1, 3'b111, 1, 0, 0);
        drive(1, 3'b110, 1, 0, 0);
        drive(1, 3'b101, 1, 0, 0);
        drive(1, 3'b111, 1, 0, 0);
        check("t5_sat", err_count, CMAX);
        drive(1, 3'b000, 1, 1, 0);
        check("t5_clr", err_count, 0);
        drive(0, 3'b000, 1, 0, 0);

        // Backpressure hold, then streaming release
        drive(1, 3'b010, 0, 0, 0);
        drive(1, 3'b011, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'b001, 0, 0, 0);
            check("t4_hold_data", out_data, 4'b1011);
            check("t4_hold_valid", out_valid, 1);
            check("t4_in_ready", in_ready, 0);
        end
        drive(1, 3'b001, 1, 0, 0);
        drive(1, 3'b010, 1, 0, 0);
        check("t4_next_word", out_data, 4'b0110);
        check("t4_next_valid", out_valid, 1);

        // Randomized traffic
        begin
            int start_acc = n_acc;
            int budget = 0;
            while (n_acc - start_acc < 1000 && budget < 5000) begin
                drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), 0);
                budget++;
            end
            check("rand_progress", (n_acc - start_acc >= 1000), 1);
        end

        // Reset mid-word discards the partial code
        drive(0, 3'b000, 1, 0, 0);
        drive(0, 3'b000, 1, 0, 0);
        drive(1, 3'b011, 1, 0, 0);
        drive(0, 3'b000, 1, 0, 1);
        drive(1, 3'b001, 1, 0, 0);
        drive(1, 3'b010, 1, 0, 0);
        check("t6_data", out_data, 4'b0110);
        check("t6_valid", out_valid, 1);

        // Reset while a word is held
        drive(1, 3'b011, 0, 0, 0);
        drive(1, 3'b010, 0, 0, 0);
        check("t6_held", out_valid, 1);
        drive(0, 3'b000, 0, 0, 1);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_ready", in_ready, 1);
        drive(0, 3'b000, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
